// File: rtl/riscv_pkg.sv
// Shared M-extension definitions: funct3 op-codes, FSM state encoding and
// small decode helpers used by the multiply/divide unit.
package riscv_pkg;

    localparam logic [2:0] F3_MUL    = 3'd0;
    localparam logic [2:0] F3_MULH   = 3'd1;
    localparam logic [2:0] F3_MULHSU = 3'd2;
    localparam logic [2:0] F3_MULHU  = 3'd3;
    localparam logic [2:0] F3_DIV    = 3'd4;
    localparam logic [2:0] F3_DIVU   = 3'd5;
    localparam logic [2:0] F3_REM    = 3'd6;
    localparam logic [2:0] F3_REMU   = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic is_div_op(input logic [2:0] f);
        return f[2];
    endfunction

    function automatic logic is_rem_op(input logic [2:0] f);
        return (f == F3_REM) || (f == F3_REMU);
    endfunction

    function automatic logic rs1_signed(input logic [2:0] f);
        return (f == F3_MUL) || (f == F3_MULH) || (f == F3_MULHSU) ||
               (f == F3_DIV) || (f == F3_REM);
    endfunction

    function automatic logic rs2_signed(input logic [2:0] f);
        return (f == F3_MUL) || (f == F3_MULH) || (f == F3_DIV) || (f == F3_REM);
    endfunction

endpackage

// File: rtl/riscv_div_step.sv
// One restoring-division iteration on magnitudes: shift in the next dividend
// bit, trial-subtract the divisor, keep the difference when it does not borrow.
module riscv_div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem,
    input  logic            dividend_bit,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_next,
    output logic            quo_bit
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    // rem < divisor holds on entry, so shifted < 2*divisor and the extra
    // top bit of diff is a clean borrow flag.
    assign shifted  = {rem, dividend_bit};
    assign diff     = shifted - {1'b0, divisor};
    assign quo_bit  = ~diff[XLEN];
    assign rem_next = quo_bit ? diff[XLEN-1:0] : shifted[XLEN-1:0];

endmodule

// File: rtl/riscv_mul_div_unit.sv
// Iterative RISC-V M-extension unit: shift-add multiplier with early exit,
// restoring divider, sign correction applied once when the result registers.
module riscv_mul_div_unit
    import riscv_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int MUL_BITS = 1,
    parameter int TAG_W    = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_funct3,
    input  logic [XLEN-1:0]  in_s1,
    input  logic [XLEN-1:0]  in_s2,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_rd,
    output logic [TAG_W-1:0] out_tag,
    input  logic             flush,
    output logic             busy
);

    localparam int CW     = $clog2(XLEN);
    localparam int NBYTES = XLEN / 8;
    localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

    state_t state, next_state;

    logic [2:0]        op_q;
    logic              neg_res_q;
    logic              neg_rem_q;
    logic [XLEN-1:0]   dvd_q;
    logic [XLEN-1:0]   dvs_q;
    logic [XLEN-1:0]   mplier_q;
    logic [XLEN-1:0]   quo_q;
    logic [XLEN-1:0]   rem_q;
    logic [2*XLEN-1:0] mcand_q;
    logic [2*XLEN-1:0] acc_q;
    logic [CW-1:0]     cnt_q;

    // Request decode: magnitudes, signs and the single-cycle special cases.
    logic            accept;
    logic            s1_neg, s2_neg;
    logic [XLEN-1:0] s1_abs, s2_abs;
    logic            mul_zero, div_zero, div_ovf, fast;
    logic [XLEN-1:0] fast_rd;
    logic [CW-1:0]   start_cnt;

    assign accept   = (state == ST_IDLE) && in_valid && !flush;
    assign s1_neg   = rs1_signed(in_funct3) && in_s1[XLEN-1];
    assign s2_neg   = rs2_signed(in_funct3) && in_s2[XLEN-1];
    assign s1_abs   = s1_neg ? (~in_s1 + 1'b1) : in_s1;
    assign s2_abs   = s2_neg ? (~in_s2 + 1'b1) : in_s2;
    assign mul_zero = !is_div_op(in_funct3) && ((in_s1 == '0) || (in_s2 == '0));
    assign div_zero = is_div_op(in_funct3) && (in_s2 == '0);
    assign div_ovf  = ((in_funct3 == F3_DIV) || (in_funct3 == F3_REM)) &&
                      (in_s1 == XMIN) && (in_s2 == '1);
    assign fast     = mul_zero || div_zero || div_ovf;

    always_comb begin
        fast_rd = '0;
        if (div_zero) begin
            fast_rd = is_rem_op(in_funct3) ? in_s1 : '1;
        end else if (div_ovf) begin
            fast_rd = is_rem_op(in_funct3) ? '0 : XMIN;
        end
    end

    // Division skips leading zero bytes of the dividend but always runs a full byte.
    always_comb begin
        start_cnt = CW'(7);
        for (int b = 1; b < NBYTES; b++) begin
            if (s1_abs[8*b +: 8] != 8'h00) begin
                start_cnt = CW'(8*b + 7);
            end
        end
    end

    // Multiplier step: retire MUL_BITS multiplier bits into the accumulator.
    logic [2*XLEN-1:0] pp, acc_nx, mcand_nx;
    logic [XLEN-1:0]   mplier_nx;
    logic              mul_last;

    always_comb begin
        pp = '0;
        for (int i = 0; i < MUL_BITS; i++) begin
            if (mplier_q[i]) begin
                pp = pp + (mcand_q << i);
            end
        end
    end

    assign acc_nx    = acc_q + pp;
    assign mplier_nx = mplier_q >> MUL_BITS;
    assign mcand_nx  = mcand_q << MUL_BITS;
    assign mul_last  = (mplier_nx == '0);

    logic [XLEN-1:0] rem_nx, quo_nx;
    logic            quo_bit;
    logic            div_last;

    riscv_div_step #(.XLEN(XLEN)) u_div_step (
        .rem          (rem_q),
        .dividend_bit (dvd_q[cnt_q]),
        .divisor      (dvs_q),
        .rem_next     (rem_nx),
        .quo_bit      (quo_bit)
    );

    assign quo_nx   = (quo_q << 1) | XLEN'(quo_bit);
    assign div_last = (cnt_q == '0);

    // Result formatting from the final-iteration values, sign applied here only.
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, calc_rd;
    logic              calc_last;

    assign prod_fix  = neg_res_q ? (~acc_nx + 1'b1) : acc_nx;
    assign quo_fix   = neg_res_q ? (~quo_nx + 1'b1) : quo_nx;
    assign rem_fix   = neg_rem_q ? (~rem_nx + 1'b1) : rem_nx;
    assign calc_last = is_div_op(op_q) ? div_last : mul_last;

    always_comb begin
        calc_rd = prod_fix[2*XLEN-1:XLEN];
        if (is_div_op(op_q)) begin
            calc_rd = is_rem_op(op_q) ? rem_fix : quo_fix;
        end else if (op_q == F3_MUL) begin
            calc_rd = prod_fix[XLEN-1:0];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if (flush) begin
            next_state = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (in_valid)  next_state = fast ? ST_DONE : ST_CALC;
                ST_CALC: if (calc_last) next_state = ST_DONE;
                ST_DONE: if (out_ready) next_state = ST_IDLE;
                default:                next_state = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            op_q      <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            mplier_q  <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            mcand_q   <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            out_rd    <= '0;
            out_tag   <= '0;
        end else if (accept) begin
            op_q      <= in_funct3;
            out_tag   <= in_tag;
            neg_res_q <= s1_neg ^ s2_neg;
            neg_rem_q <= s1_neg;
            dvd_q     <= s1_abs;
            dvs_q     <= s2_abs;
            mplier_q  <= s2_abs;
            mcand_q   <= {{XLEN{1'b0}}, s1_abs};
            acc_q     <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            cnt_q     <= start_cnt;
            if (fast) begin
                out_rd <= fast_rd;
            end
        end else if ((state == ST_CALC) && !flush) begin
            if (is_div_op(op_q)) begin
                rem_q <= rem_nx;
                quo_q <= quo_nx;
                cnt_q <= cnt_q - CW'(1);
            end else begin
                acc_q    <= acc_nx;
                mplier_q <= mplier_nx;
                mcand_q  <= mcand_nx;
            end
            if (calc_last) begin
                out_rd <= calc_rd;
            end
        end
    end

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign busy      = (state != ST_IDLE);

endmodule
